decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//   Registered RV32I/RV64I decode stage with a DEPTH-entry decoded-instruction queue.
//   Sits between fetch and register-read/execute.
//   Decodes all six formats (R/I/S/B/U/J) with correct immediate bit-scatter and write-back select.
//   Flags illegal encodings and decouples fetch from execute with a valid/ready handshake on both sides.
// PARAMETERS
//   XLEN   32  datapath width, 32 or 64; sets the sign-extension width of out_imm and legality of OP-32/OP-IMM-32
//   DEPTH  2   queue entries; power of two, >= 2
// PORTS
//   clk           in   1                    rising-edge clock
//   rst           in   1                    asynchronous, active-high reset
//   flush         in   1                    synchronous queue clear (branch redirect)
//   in_valid      in   1                    fetch presents an instruction
//   in_ready      out  1                    queue can accept
//   in_instr      in   32                   raw instruction word
//   in_pc         in   XLEN                 PC of in_instr
//   out_valid     out  1                    head entry valid
//   out_ready     in   1                    execute consumes head
//   out_pc        out  XLEN                 PC of head
//   out_opcode    out  7                    instr[6:0]
//   out_rd        out  5                    destination register; 0 if unused
//   out_rs1       out  5                    source register 1; 0 if unused
//   out_rs2       out  5                    source register 2; 0 if unused
//   out_funct3    out  3                    funct3; 0 for U/J
//   out_funct7    out  7                    funct7; R-type only, else 0
//   out_imm       out  XLEN                 sign-extended immediate for the format; 0 for R-type
//   out_wb_sel    out  2                    00 ALU, 01 load data, 10 PC+4, 11 immediate (LUI)
//   out_reg_write out  1                    writes rd; 0 for STORE/BRANCH/illegal, or when rd==0
//   out_illegal   out  1                    head is an illegal encoding
//   count         out  $clog2(DEPTH+1)      occupied entries
// BEHAVIOUR
//   - Reset: every output is 0, including count, out_valid and in_ready.
//     in_ready rises in the first cycle after rst deasserts.
//     Async assert; deassert is used synchronously.
//   - Handshakes:
//     - push = in_valid & in_ready; pop = out_valid & out_ready.
//     - in_ready = (count < DEPTH), registered-state only; no combinational path from out_ready to in_ready.
//     - When full, a same-cycle pop does not enable a push.
//   - Latency:
//     - Decode is combinational on the input side; the decoded record is written into the queue.
//     - An instruction pushed at edge N drives out_* and out_valid=1 from edge N onward (1 cycle, no bypass).
//   - Queue:
//     - Circular buffer; read/write pointers wrap modulo DEPTH.
//     - Simultaneous push and pop when 0 < count < DEPTH leaves count unchanged.
//     - Pop when empty and push when full are impossible by construction.
//   - out_* while out_valid=0: all fields 0.
//   - flush: next edge sets count=0 and pointers=0.
//     - A push in the flush cycle is discarded; a pop in that cycle is still considered consumed.
//     - flush has priority over push/pop.
//   - Opcode map (instr[6:2], instr[1:0] must be 11):
//     | group              | instr[6:2]  | fields driven          | out_wb_sel |
//     |--------------------|-------------|------------------------|------------|
//     | OP                 | 01100       | rd, rs1, rs2, f3, f7   | 00         |
//     | OP-32              | 01110       | rd, rs1, rs2, f3, f7   | 00         |
//     | OP-IMM, OP-IMM-32  | 00100/00110 | rd, rs1, f3, imm I     | 00         |
//     | LOAD               | 00000       | rd, rs1, f3, imm I     | 01         |
//     | JALR               | 11001       | rd, rs1, f3, imm I     | 10         |
//     | SYSTEM             | 11100       | rd, rs1, f3, imm I     | 00         |
//     | STORE              | 01000       | rs1, rs2, f3, imm S    | 00         |
//     | BRANCH             | 11000       | rs1, rs2, f3, imm B    | 00         |
//     | LUI                | 01101       | rd, imm U              | 11         |
//     | AUIPC              | 00101       | rd, imm U              | 00         |
//     | JAL                | 11011       | rd, imm J              | 10         |
//   - Immediates, sign-extended from instr[31] to XLEN:
//     - I = instr[31:20]
//     - S = {instr[31:25], instr[11:7]}
//     - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//     - U = {instr[31:12], 12'b0}
//     - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//   - Illegal when any of:
//     - instr[1:0] != 11
//     - unlisted opcode
//     - OP-32/OP-IMM-32 with XLEN==32
//   - Illegal entries are still queued: out_illegal=1, pc and opcode kept, all other fields 0, out_reg_write=0.
//   - Reset mid-operation empties the queue immediately. Entries in flight are lost; no partial record is ever presented.
// TESTING
//   1. Reset: rst=1 mid-stream -> all outputs 0 during reset; in_ready=1 one cycle after release.
//   2. Decode: push 0x00500093 (addi x1,x0,5) -> out_rd=1, out_imm=5, out_wb_sel=00, out_reg_write=1, next cycle.
//   3. Immediates: push 0xFE000EE3 (beq x0,x0,-4) -> out_imm=-4 (0xFFFFFFFC), out_reg_write=0.
//      Push 0x0000006F (jal x0,0) -> out_imm=0, out_reg_write=0.
//   4. LUI/illegal: push 0x123450B7 -> out_imm=0x12345000, out_wb_sel=11.
//      Push 0x00000000 -> out_illegal=1, out_reg_write=0.
//      With XLEN=32, push 0x0000003B -> out_illegal=1.
//   5. Backpressure: out_ready=0, push 3 with DEPTH=2 -> count=2, in_ready=0, third held by fetch.
//      Release -> FIFO order preserved; simultaneous push/pop keeps count.
//   6. Flush: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, pushed word discarded.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage: combinational decode into a DEPTH-entry
// circular queue with valid/ready handshakes on the fetch and execute sides.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [6:0]                   out_opcode,
  output logic [4:0]                   out_rd,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [2:0]                   out_funct3,
  output logic [6:0]                   out_funct7,
  output logic [XLEN-1:0]              out_imm,
  output logic [1:0]                   out_wb_sel,
  output logic                         out_reg_write,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic        RV64 = (XLEN == 64);

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_OP32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [1:0]      wb_sel;
    logic            reg_write;
    logic            illegal;
  } rec_t;

  rec_t            r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;

  rec_t            w_dec;
  rec_t            w_head;
  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
  logic            w_legal, w_use_rd, w_use_rs1, w_use_rs2, w_use_f3, w_use_f7;
  logic [1:0]      w_wb;
  logic            w_push, w_pop;
  logic [CW-1:0]   w_count_nxt;

  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  // Format classification; illegal encodings keep only pc and opcode.
  always_comb begin
    w_legal   = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_f3  = 1'b0;
    w_use_f7  = 1'b0;
    w_wb      = WB_ALU;
    w_imm32   = '0;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:2])
        OPC_OP, OPC_OP32: begin
          w_legal   = (in_instr[6:2] == OPC_OP) || RV64;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_use_f3  = 1'b1;
          w_use_f7  = 1'b1;
        end
        OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
          w_legal   = (in_instr[6:2] != OPC_OP_IMM32) || RV64;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_f3  = 1'b1;
          w_imm32   = w_imm_i;
          if (in_instr[6:2] == OPC_LOAD) w_wb = WB_MEM;
          if (in_instr[6:2] == OPC_JALR) w_wb = WB_PC4;
        end
        OPC_STORE, OPC_BRANCH: begin
          w_legal   = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_use_f3  = 1'b1;
          w_imm32   = (in_instr[6:2] == OPC_STORE) ? w_imm_s : w_imm_b;
        end
        OPC_LUI, OPC_AUIPC: begin
          w_legal  = 1'b1;
          w_use_rd = 1'b1;
          w_imm32  = w_imm_u;
          if (in_instr[6:2] == OPC_LUI) w_wb = WB_IMM;
        end
        OPC_JAL: begin
          w_legal  = 1'b1;
          w_use_rd = 1'b1;
          w_imm32  = w_imm_j;
          w_wb     = WB_PC4;
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_dec        = '0;
    w_dec.pc     = in_pc;
    w_dec.opcode = in_instr[6:0];
    if (w_legal) begin
      w_dec.rd        = w_use_rd  ? in_instr[11:7]  : 5'd0;
      w_dec.rs1       = w_use_rs1 ? in_instr[19:15] : 5'd0;
      w_dec.rs2       = w_use_rs2 ? in_instr[24:20] : 5'd0;
      w_dec.funct3    = w_use_f3  ? in_instr[14:12] : 3'd0;
      w_dec.funct7    = w_use_f7  ? in_instr[31:25] : 7'd0;
      w_dec.imm       = XLEN'($signed(w_imm32));
      w_dec.wb_sel    = w_wb;
      w_dec.reg_write = w_use_rd && (in_instr[11:7] != 5'd0);
    end else begin
      w_dec.illegal   = 1'b1;
    end
  end

  // in_ready comes only from registered state, so full+pop cannot admit a push.
  assign w_push = in_valid && r_in_ready;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= w_dec;
  end

  assign out_valid = (r_count != '0);
  assign in_ready  = r_in_ready;
  assign count     = r_count;
  assign w_head    = out_valid ? r_mem[r_rd_ptr] : '0;

  assign out_pc        = w_head.pc;
  assign out_opcode    = w_head.opcode;
  assign out_rd        = w_head.rd;
  assign out_rs1       = w_head.rs1;
  assign out_rs2       = w_head.rs2;
  assign out_funct3    = w_head.funct3;
  assign out_funct7    = w_head.funct7;
  assign out_imm       = w_head.imm;
  assign out_wb_sel    = w_head.wb_sel;
  assign out_reg_write = w_head.reg_write;
  assign out_illegal   = w_head.illegal;

endmodule
